// File: rtl/shift_issue_buffer_pkg.sv
// Shared definitions for the shift issue buffer.
// Holds the shifter operation codes, the MIPS R-type shift funct codes,
// the skid buffer state encoding and the log2 helper that sizes the amount field.
package shift_issue_buffer_pkg;

    // Shifter operation codes, as expected on the shifter's i_operation input
    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_ROR = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    // R-type funct field values of the shift instructions
    localparam logic [5:0] FUNCT_SLL  = 6'b000000;
    localparam logic [5:0] FUNCT_SRL  = 6'b000010;
    localparam logic [5:0] FUNCT_SRA  = 6'b000011;
    localparam logic [5:0] FUNCT_SLLV = 6'b000100;
    localparam logic [5:0] FUNCT_SRLV = 6'b000110;
    localparam logic [5:0] FUNCT_SRAV = 6'b000111;

    // Skid buffer occupancy: nothing, main register only, main plus skid
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_MAIN  = 2'b01,
        ST_FULL  = 2'b10
    } skid_state_e;

    // Ceiling log2, used to size the shift amount from the data width
    function automatic int log2_ceil(input int value);
        int width;
        width = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                width = i + 1;
            end
        end
        return width;
    endfunction

endpackage

// File: rtl/shift_issue_buffer_decode.sv
// Combinational decode of a MIPS R-type shift instruction.
// Ports:
//   i_funct      - instruction funct field
//   i_rbit       - rotate select (already muxed by the decode stage)
//   i_shamt      - instruction shamt field, used by the fixed forms
//   i_rs_amount  - low bits of rs, used by the variable forms
//   o_operation  - shifter operation code
//   o_amount     - shift amount
//   o_illegal    - funct is not a shift
module shift_issue_buffer_decode
    import shift_issue_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic [5:0]            i_funct,
    input  logic                  i_rbit,
    input  logic [4:0]            i_shamt,
    input  logic [ADDR_WIDTH-1:0] i_rs_amount,
    output logic [1:0]            o_operation,
    output logic [ADDR_WIDTH-1:0] o_amount,
    output logic                  o_illegal
);

    logic [ADDR_WIDTH-1:0] shamt_s;

    // Size cast truncates shamt for narrow datapaths and zero-extends for wide ones
    assign shamt_s = ADDR_WIDTH'(i_shamt);

    // Map funct/rbit to operation and amount source; non-shifts become a flagged SLL by 0
    always_comb begin
        o_operation = OP_SLL;
        o_amount    = '0;
        o_illegal   = 1'b0;
        case (i_funct)
            FUNCT_SLL: begin
                o_amount = shamt_s;
            end
            FUNCT_SRL: begin
                o_operation = i_rbit ? OP_ROR : OP_SRL;
                o_amount    = shamt_s;
            end
            FUNCT_SRA: begin
                o_operation = OP_SRA;
                o_amount    = shamt_s;
            end
            FUNCT_SLLV: begin
                o_amount = i_rs_amount;
            end
            FUNCT_SRLV: begin
                o_operation = i_rbit ? OP_ROR : OP_SRL;
                o_amount    = i_rs_amount;
            end
            FUNCT_SRAV: begin
                o_operation = OP_SRA;
                o_amount    = i_rs_amount;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/shift_issue_buffer.sv
// Execute-stage front end of the shift unit: decodes shift instructions and
// holds the decoded operands in a 2-entry skid buffer (main + skid).
// Ports:
//   i_clk, i_rst     - clock, synchronous active-high reset
//   i_flush          - discard all buffered entries and the offered input
//   i_valid/o_ready  - upstream handshake (o_ready is registered)
//   i_funct, i_rbit, i_shamt, i_rs_data, i_rt_data - instruction fields/operands
//   o_valid/i_ready  - downstream handshake
//   o_operation, o_amount, o_din, o_illegal - decoded entry for the shifter
module shift_issue_buffer
    import shift_issue_buffer_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    localparam int ADDR_WIDTH = log2_ceil(DATA_WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [5:0]            i_funct,
    input  logic                  i_rbit,
    input  logic [4:0]            i_shamt,
    input  logic [DATA_WIDTH-1:0] i_rs_data,
    input  logic [DATA_WIDTH-1:0] i_rt_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [1:0]            o_operation,
    output logic [ADDR_WIDTH-1:0] o_amount,
    output logic [DATA_WIDTH-1:0] o_din,
    output logic                  o_illegal
);

    skid_state_e           state_q;
    logic                  valid_q;
    logic                  ready_q;
    logic [1:0]            main_op_q;
    logic [ADDR_WIDTH-1:0] main_amt_q;
    logic [DATA_WIDTH-1:0] main_din_q;
    logic                  main_ill_q;
    logic [1:0]            skid_op_q;
    logic [ADDR_WIDTH-1:0] skid_amt_q;
    logic [DATA_WIDTH-1:0] skid_din_q;
    logic                  skid_ill_q;

    logic [1:0]            dec_op_s;
    logic [ADDR_WIDTH-1:0] dec_amt_s;
    logic                  dec_ill_s;
    logic                  in_fire_s;
    logic                  out_fire_s;
    logic                  unused_rs_s;

    // Only the low rs bits can ever form a shift amount
    assign unused_rs_s = ^i_rs_data[DATA_WIDTH-1:ADDR_WIDTH];

    shift_issue_buffer_decode #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_decode (
        .i_funct     (i_funct),
        .i_rbit      (i_rbit),
        .i_shamt     (i_shamt),
        .i_rs_amount (i_rs_data[ADDR_WIDTH-1:0]),
        .o_operation (dec_op_s),
        .o_amount    (dec_amt_s),
        .o_illegal   (dec_ill_s)
    );

    assign in_fire_s  = i_valid & ready_q;
    assign out_fire_s = valid_q & i_ready;

    // Skid buffer FSM; handshake flags are registered alongside the state so
    // o_ready never sees i_ready combinationally. Data registers load only on transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_EMPTY;
            valid_q    <= 1'b0;
            ready_q    <= 1'b1;
            main_op_q  <= OP_SLL;
            main_amt_q <= '0;
            main_din_q <= '0;
            main_ill_q <= 1'b0;
            skid_op_q  <= OP_SLL;
            skid_amt_q <= '0;
            skid_din_q <= '0;
            skid_ill_q <= 1'b0;
        end else if (i_flush) begin
            // Offered input is dropped; a concurrent output transfer simply completes
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire_s) begin
                        main_op_q  <= dec_op_s;
                        main_amt_q <= dec_amt_s;
                        main_din_q <= i_rt_data;
                        main_ill_q <= dec_ill_s;
                        state_q    <= ST_MAIN;
                        valid_q    <= 1'b1;
                    end
                end
                ST_MAIN: begin
                    if (in_fire_s && out_fire_s) begin
                        main_op_q  <= dec_op_s;
                        main_amt_q <= dec_amt_s;
                        main_din_q <= i_rt_data;
                        main_ill_q <= dec_ill_s;
                    end else if (in_fire_s) begin
                        skid_op_q  <= dec_op_s;
                        skid_amt_q <= dec_amt_s;
                        skid_din_q <= i_rt_data;
                        skid_ill_q <= dec_ill_s;
                        state_q    <= ST_FULL;
                        ready_q    <= 1'b0;
                    end else if (out_fire_s) begin
                        state_q <= ST_EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (out_fire_s) begin
                        main_op_q  <= skid_op_q;
                        main_amt_q <= skid_amt_q;
                        main_din_q <= skid_din_q;
                        main_ill_q <= skid_ill_q;
                        state_q    <= ST_MAIN;
                        ready_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_EMPTY;
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign o_valid     = valid_q;
    assign o_ready     = ready_q;
    assign o_operation = main_op_q;
    assign o_amount    = main_amt_q;
    assign o_din       = main_din_q;
    assign o_illegal   = main_ill_q;

endmodule

// File: tb/tb_shift_issue_buffer.sv
// Self-checking bench for shift_issue_buffer: a queue-based reference model
// tracks buffered entries; outputs are compared every cycle, plus literal pins.
module tb_shift_issue_buffer;

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  amt;
        logic [31:0] din;
        logic        ill;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        valid_in;
    logic        ready_out;
    logic [5:0]  funct;
    logic        rbit;
    logic [4:0]  shamt;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        valid_out;
    logic        ready_in;
    logic [1:0]  op_out;
    logic [4:0]  amt_out;
    logic [31:0] din_out;
    logic        ill_out;

    int checks;
    int errors;
    int accepted;
    bit model_ok;
    entry_t model_q[$];
    entry_t last_out;

    shift_issue_buffer #(.DATA_WIDTH(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_flush     (flush),
        .i_valid     (valid_in),
        .o_ready     (ready_out),
        .i_funct     (funct),
        .i_rbit      (rbit),
        .i_shamt     (shamt),
        .i_rs_data   (rs_data),
        .i_rt_data   (rt_data),
        .o_valid     (valid_out),
        .i_ready     (ready_in),
        .o_operation (op_out),
        .o_amount    (amt_out),
        .o_din       (din_out),
        .o_illegal   (ill_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference decode straight from the instruction table
    function automatic entry_t decode_model(input logic [5:0] f, input logic r,
                                            input logic [4:0] sh, input logic [31:0] rs,
                                            input logic [31:0] rt);
        entry_t e;
        e.din = rt;
        e.ill = 1'b0;
        e.op  = 2'd0;
        e.amt = 5'd0;
        case (f)
            6'd0: e.amt = sh;
            6'd2: begin e.op = r ? 2'd1 : 2'd2; e.amt = sh; end
            6'd3: begin e.op = 2'd3; e.amt = sh; end
            6'd4: e.amt = rs[4:0];
            6'd6: begin e.op = r ? 2'd1 : 2'd2; e.amt = rs[4:0]; end
            6'd7: begin e.op = 2'd3; e.amt = rs[4:0]; end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: compare outputs to model at negedge, advance model, step past posedge
    task automatic tick();
        bit in_fire;
        bit out_fire;
        entry_t exp_e;
        @(negedge clk);
        if (model_ok) begin
            exp_e = (model_q.size() > 0) ? model_q[0] : last_out;
            check("o_valid", 64'(valid_out), 64'(model_q.size() > 0));
            check("o_ready", 64'(ready_out), 64'(model_q.size() < 2));
            check("o_operation", 64'(op_out), 64'(exp_e.op));
            check("o_amount", 64'(amt_out), 64'(exp_e.amt));
            check("o_din", 64'(din_out), 64'(exp_e.din));
            check("o_illegal", 64'(ill_out), 64'(exp_e.ill));
        end
        in_fire  = valid_in && (model_q.size() < 2);
        out_fire = (model_q.size() > 0) && ready_in;
        if (rst) begin
            model_q.delete();
            last_out = '0;
            model_ok = 1'b1;
        end else if (flush) begin
            model_q.delete();
        end else begin
            if (out_fire) void'(model_q.pop_front());
            if (in_fire) begin
                model_q.push_back(decode_model(funct, rbit, shamt, rs_data, rt_data));
                accepted++;
            end
        end
        if (model_q.size() > 0) last_out = model_q[0];
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [5:0] f, input logic r, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt);
        valid_in = 1'b1;
        funct    = f;
        rbit     = r;
        shamt    = sh;
        rs_data  = rs;
        rt_data  = rt;
    endtask

    initial begin
        logic [5:0] funct_tbl [8];
        entry_t pin;
        int cycles;
        funct_tbl = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7, 6'h20, 6'h2A};
        checks = 0; errors = 0; accepted = 0; model_ok = 1'b0;
        last_out = '0;
        rst = 1'b1; flush = 1'b0; valid_in = 1'b0; ready_in = 1'b1;
        funct = 6'd0; rbit = 1'b0; shamt = 5'd0; rs_data = 32'd0; rt_data = 32'd0;

        // Literal pins on the reference decode itself
        pin = decode_model(6'd6, 1'b1, 5'd0, 32'h0000_0027, 32'h8000_0001);
        check("model_srlv_rot_op", 64'(pin.op), 64'd1);
        check("model_srlv_rot_amt", 64'(pin.amt), 64'd7);
        pin = decode_model(6'h20, 1'b0, 5'd9, 32'h0000_001F, 32'h1234_5678);
        check("model_illegal", 64'({pin.ill, pin.op, pin.amt}), 64'h80);

        // Reset
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 64'(valid_out), 64'd0);
        check("rst_ready", 64'(ready_out), 64'd1);
        check("rst_fields", 64'({op_out, amt_out, din_out, ill_out}), 64'd0);

        // Single SLL
        offer(6'd0, 1'b0, 5'd4, 32'd0, 32'h0000_00F1);
        tick();
        valid_in = 1'b0;
        check("sll_valid", 64'(valid_out), 64'd1);
        check("sll_op", 64'(op_out), 64'd0);
        check("sll_amt", 64'(amt_out), 64'd4);
        check("sll_din", 64'(din_out), 64'h0000_00F1);
        tick();
        check("sll_drained", 64'(valid_out), 64'd0);

        // SRLV with rotate bit -> ROR by rs[4:0]
        offer(6'd6, 1'b1, 5'd0, 32'h0000_0027, 32'h8000_0001);
        tick();
        valid_in = 1'b0;
        check("rotrv_op", 64'(op_out), 64'd1);
        check("rotrv_amt", 64'(amt_out), 64'd7);
        check("rotrv_ill", 64'(ill_out), 64'd0);
        tick();

        // Backpressure: A, B accepted, C held off
        ready_in = 1'b0;
        offer(6'd0, 1'b0, 5'd1, 32'd0, 32'hAAAA_0001);
        tick();
        offer(6'd2, 1'b0, 5'd2, 32'd0, 32'hBBBB_0002);
        tick();
        check("bp_full_ready", 64'(ready_out), 64'd0);
        offer(6'd3, 1'b0, 5'd3, 32'd0, 32'hCCCC_0003);
        tick();
        tick();
        check("bp_hold_din", 64'(din_out), 64'hAAAA_0001);
        ready_in = 1'b1;
        tick();
        check("bp_second_din", 64'(din_out), 64'hBBBB_0002);
        tick();
        valid_in = 1'b0;
        check("bp_third_din", 64'(din_out), 64'hCCCC_0003);
        tick();
        check("bp_drained", 64'(valid_out), 64'd0);

        // Flush while FULL with D offered
        ready_in = 1'b0;
        offer(6'd0, 1'b0, 5'd5, 32'd0, 32'h1111_0001);
        tick();
        offer(6'd0, 1'b0, 5'd6, 32'd0, 32'h2222_0002);
        tick();
        flush = 1'b1;
        offer(6'd7, 1'b0, 5'd0, 32'd3, 32'hDDDD_DDDD);
        tick();
        flush = 1'b0;
        valid_in = 1'b0;
        check("flush_valid", 64'(valid_out), 64'd0);
        check("flush_ready", 64'(ready_out), 64'd1);
        ready_in = 1'b1;
        tick();
        check("flush_no_d", 64'(valid_out), 64'd0);

        // Illegal funct
        offer(6'h20, 1'b1, 5'd9, 32'h0000_001F, 32'h5A5A_A5A5);
        tick();
        valid_in = 1'b0;
        check("illegal_flag", 64'(ill_out), 64'd1);
        check("illegal_op_amt", 64'({op_out, amt_out}), 64'd0);
        check("illegal_din", 64'(din_out), 64'h5A5A_A5A5);
        tick();

        // Random streaming with random backpressure
        accepted = 0;
        cycles = 0;
        while (accepted < 100 && cycles < 3000) begin
            offer(funct_tbl[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                  5'($urandom), $urandom, $urandom);
            valid_in = ($urandom_range(0, 3) != 0);
            ready_in = 1'($urandom_range(0, 1));
            flush    = ($urandom_range(0, 39) == 0);
            tick();
            cycles++;
        end
        flush = 1'b0;
        valid_in = 1'b0;
        ready_in = 1'b1;
        check("stream_budget", 64'(accepted >= 100), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        check("stream_drained", 64'(valid_out), 64'd0);

        // Reset mid-operation discards entries
        ready_in = 1'b0;
        offer(6'd4, 1'b0, 5'd0, 32'd9, 32'h7777_7777);
        tick();
        valid_in = 1'b0;
        rst = 1'b1;
        flush = 1'b1;
        tick();
        rst = 1'b0;
        flush = 1'b0;
        check("midrst_valid", 64'(valid_out), 64'd0);
        check("midrst_din", 64'(din_out), 64'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
